tube_xfer_fifo: RTL and testbench

- Parametrised single-clock FIFO carrying bytes (or wider words) from the parasite side to the host side of the Tube.
- Successor to the fixed 8-bit, vendor-core parasite-to-host FIFO: generic width and depth, first-word-fall-through read, and fill value on empty reads.
- Adds a programmable data-available threshold, a level count and a synchronous flush.
- Both sides are qualified by clock enables derived from phi2 on the system clock; it sits between the parasite bus decode and the host register read mux.

---
 rtl/tube_pkg.sv | 17 +
 rtl/tube_fifo_ram.sv | 33 +++
 rtl/tube_xfer_fifo.sv | 117 +++++++++++
 tb/tb_tube_xfer_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared constants and width helpers for the Tube parasite-to-host FIFO.
package tube_pkg;

    // Value presented on the host data bus when the FIFO holds nothing.
    localparam logic [7:0] TUBE_FIFO_FILL = 8'hAA;

    // Pointer width: enough bits to address DEPTH entries, never below 1.
    function automatic int tube_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Level width: DEPTH itself must be representable, so count 0..DEPTH.
    function automatic int tube_level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tube_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, so the
// array can map onto distributed RAM.
module tube_fifo_ram
    import tube_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [tube_ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [tube_ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]             rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one word per enabled cycle.
    // NOTE: the array has no reset so it stays a plain RAM; stale words are
    // never visible because the level gates h_data to the fill value.
    // NOTE: sequential state is updated with <= so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational for zero-latency head-of-queue access.
    assign rdata = mem[raddr];

endmodule

// File: rtl/tube_xfer_fifo.sv
// Parasite-to-host Tube FIFO: first-word-fall-through read, fill value on
// empty, programmable data-available threshold, level count and flush.
// Optional build macro TUBE_FIFO_ERRFLAGS_EN adds sticky overflow and
// underflow outputs.
module tube_xfer_fifo
    import tube_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 16,
    parameter logic [WIDTH-1:0] FILL  = WIDTH'(TUBE_FIFO_FILL)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           p_wr_en,
    input  logic [WIDTH-1:0]               p_data,
    input  logic                           h_rd_en,
    input  logic [tube_level_w(DEPTH)-1:0] threshold,
    output logic [WIDTH-1:0]               h_data,
    output logic                           h_data_available,
    output logic                           p_full,
`ifdef TUBE_FIFO_ERRFLAGS_EN
    output logic                           overflow,
    output logic                           underflow,
`endif
    output logic [tube_level_w(DEPTH)-1:0] level
);

    localparam int AW = tube_ptr_w(DEPTH);
    localparam int LW = tube_level_w(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic [LW-1:0]    thr_eff;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;
    logic             ram_we;
    logic [WIDTH-1:0] ram_rdata;

    // Status decoded from the registered level only, so a same-cycle pop
    // never makes room for a push while full.
    assign empty   = (level == '0);
    assign p_full  = (level == LW'(DEPTH));
    assign push_ok = p_wr_en && !p_full;
    assign pop_ok  = h_rd_en && !empty;

    // A flushed or reset cycle writes nothing, keeping the RAM quiet.
    assign ram_we  = push_ok && !flush && !rst;

    // Threshold 0 behaves as 1: "any data" is the weakest useful condition.
    assign thr_eff          = (threshold == '0) ? LW'(1) : threshold;
    assign h_data_available = (level >= thr_eff);

    assign h_data = empty ? FILL : ram_rdata;

    tube_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (p_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Next occupancy: +1 for an accepted push, -1 for an accepted pop.
    // NOTE: level_next gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        level_next = level;
        if (push_ok && !pop_ok) begin
            level_next = level + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_next = level - LW'(1);
        end
    end

    // Pointer and level registers; reset and flush clear them identically.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
        end
    end

`ifdef TUBE_FIFO_ERRFLAGS_EN
    // Sticky error flags: reset or flush clears them, otherwise a dropped
    // push or ignored pop sets them.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (p_wr_en && p_full) begin
                overflow <= 1'b1;
            end
            if (h_rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tube_xfer_fifo.sv
// Self-checking bench for tube_xfer_fifo: a vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_tube_xfer_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam logic [7:0] FILL_V = 8'hAA;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          p_wr_en;
    logic [7:0]    p_data;
    logic          h_rd_en;
    logic [LW-1:0] threshold;
    logic [7:0]    h_data;
    logic          h_data_available;
    logic          p_full;
    logic [LW-1:0] level;
`ifdef TUBE_FIFO_ERRFLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    always #5 clk = ~clk;

    tube_xfer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .p_wr_en          (p_wr_en),
        .p_data           (p_data),
        .h_rd_en          (h_rd_en),
        .threshold        (threshold),
        .h_data           (h_data),
        .h_data_available (h_data_available),
        .p_full           (p_full),
`ifdef TUBE_FIFO_ERRFLAGS_EN
        .overflow         (overflow),
        .underflow        (underflow),
`endif
        .level            (level)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a queue, flags as plain bits.
    byte unsigned model_q[$];
    bit           m_ovf;
    bit           m_unf;
    int           cur_thr;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          wr;
        logic [7:0]  data;
        bit          rd;
        int          thr;
        logic [7:0]  exp_h;
        int          exp_level;
        bit          exp_avail;
        bit          exp_full;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and return #1 after the edge.
    task automatic drive(input bit r, input bit f, input bit w, input logic [7:0] d,
                         input bit rd, input int thr);
        bit full_pre;
        bit empty_pre;
        rst       = r;
        flush     = f;
        p_wr_en   = w;
        p_data    = d;
        h_rd_en   = rd;
        threshold = LW'(thr);
        cur_thr   = thr;
        full_pre  = (model_q.size() == DEPTH);
        empty_pre = (model_q.size() == 0);
        if (r || f) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && full_pre)  m_ovf = 1'b1;
            if (rd && empty_pre) m_unf = 1'b1;
            if (rd && !empty_pre) void'(model_q.pop_front());
            if (w && !full_pre) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_with_thr(input int thr);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, thr);
    endtask

    // Compare every output against the model state.
    task automatic check_model(input string tag);
        int          n;
        int          t;
        logic [7:0]  exp_h;
        n     = model_q.size();
        t     = (cur_thr == 0) ? 1 : cur_thr;
        exp_h = (n == 0) ? FILL_V : model_q[0];
        check({tag, "_level"}, level, n);
        check({tag, "_hdata"}, h_data, exp_h);
        check({tag, "_avail"}, h_data_available, (n >= t) ? 1 : 0);
        check({tag, "_full"},  p_full, (n == DEPTH) ? 1 : 0);
`ifdef TUBE_FIFO_ERRFLAGS_EN
        check({tag, "_ovf"}, overflow, m_ovf);
        check({tag, "_unf"}, underflow, m_unf);
`endif
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; p_wr_en = 1'b0; p_data = '0; h_rd_en = 1'b0;
        threshold = '0; cur_thr = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- vector table ----------------
        //          rst flush wr data   rd thr  exp_h  lvl av full
        vecs[0] = '{1, 0, 0, 8'h00, 0, 0, 8'hAA, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 8'h00, 1, 0, 8'hAA, 0, 0, 0};
        vecs[2] = '{0, 0, 1, 8'h3C, 0, 2, 8'h3C, 1, 0, 0};
        vecs[3] = '{0, 0, 1, 8'hC3, 0, 2, 8'h3C, 2, 1, 0};
        vecs[4] = '{0, 0, 0, 8'h00, 1, 2, 8'hC3, 1, 0, 0};
        vecs[5] = '{0, 0, 0, 8'h00, 0, 0, 8'hC3, 1, 1, 0};
        vecs[6] = '{0, 0, 1, 8'h77, 1, 1, 8'h77, 1, 1, 0};
        vecs[7] = '{0, 1, 1, 8'h99, 0, 1, 8'hAA, 0, 0, 0};
        vecs[8] = '{0, 0, 1, 8'h5A, 1, 1, 8'h5A, 1, 1, 0};
        vecs[9] = '{0, 0, 0, 8'h00, 1, 1, 8'hAA, 0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].thr);
            check($sformatf("vec%0d_hdata", i), h_data, vecs[i].exp_h);
            check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            check($sformatf("vec%0d_avail", i), h_data_available, vecs[i].exp_avail);
            check($sformatf("vec%0d_full", i), p_full, vecs[i].exp_full);
`ifdef TUBE_FIFO_ERRFLAGS_EN
            if (i == 1) check("vec1_underflow", underflow, 1);
`endif
        end

        // ---------------- fill and drain ----------------
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1);
        end
        check("fill_full", p_full, 1);
        check("fill_level", level, DEPTH);
        drive(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1);
        check("drop_level", level, DEPTH);
        check("drop_head", h_data, 8'h01);
`ifdef TUBE_FIFO_ERRFLAGS_EN
        check("drop_overflow", overflow, 1);
`endif
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("drain_%0d", i), h_data, 8'(i));
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1);
        end
        check("drain_empty_fill", h_data, 8'hAA);
        check("drain_empty_level", level, 0);

        // ---------------- simultaneous push/pop at level 5 ----------------
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 3);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("sim5_head_%0d", i), h_data, 8'(8'h20 + i));
            drive(1'b0, 1'b0, 1'b1, 8'(8'h25 + i), 1'b1, 3);
            check($sformatf("sim5_level_%0d", i), level, 5);
        end
        check_model("sim5_end");

        // ---------------- simultaneous push/pop at full ----------------
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 1);
        check("simfull_level", level, DEPTH - 1);
        check("simfull_not_full", p_full, 0);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("simfull_drain_%0d", i), h_data, 8'(8'h80 + i));
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1);
        end
        check("simfull_absent", h_data, 8'hAA);

        // ---------------- simultaneous push/pop at empty ----------------
        drive(1'b0, 1'b0, 1'b1, 8'h6B, 1'b1, 1);
        check("simempty_level", level, 1);
        check("simempty_hdata", h_data, 8'h6B);
`ifdef TUBE_FIFO_ERRFLAGS_EN
        check("simempty_underflow", underflow, 1);
`endif
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1);

        // ---------------- wrap-around ----------------
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 8'(r * 3 + k + 1), 1'b0, 1);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("wrap_%0d_%0d", r, k), h_data, 8'(r * 3 + k + 1));
                drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1);
            end
        end
        check_model("wrap_end");

        // ---------------- flush mid-stream ----------------
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1);
        check("preflush_level", level, 7);
        drive(1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1);
        check("flush_level", level, 0);
        check("flush_hdata", h_data, 8'hAA);
        drive(1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 1);
        check("postflush_hdata", h_data, 8'h42);
        check("postflush_level", level, 1);

        // ---------------- randomized run against the model ----------------
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int          pw;
            bit          w;
            bit          rd;
            bit          f;
            bit          r;
            logic [7:0]  d;
            pw = ((cyc / 200) % 2 == 0) ? 75 : 30;
            w  = ($urandom_range(0, 99) < pw);
            rd = ($urandom_range(0, 99) < 50);
            f  = ($urandom_range(0, 99) == 0);
            r  = ($urandom_range(0, 299) == 0);
            d  = 8'($urandom);
            drive(r, f, w, d, rd, $urandom_range(0, DEPTH + 1));
            check_model($sformatf("rand%0d", cyc));
            if (failures > 20) break;
        end

        idle_with_thr(0);
        check_model("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
